// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file.
//   state_t  : frame state machine encoding (IDLE, HDR, DATA, OVF)
//   RW_*     : value of the first frame bit for write / read
//   frame_w(): total frame length = R/W bit + address + data
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    OVF  = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_rw_if.sv
// SPI pin bundle between a bus master and the register file.
// There is no valid/ready pairing on this link: a frame is valid for as long
// as cs is low, sdi is sampled on sclk rising edges (mode 0, sclk idle low),
// and sdo is only meaningful while sdo_oe is 1.
//   master : drives sclk, sdi, cs; observes sdo, sdo_oe
//   slave  : observes sclk, sdi, cs; drives sdo, sdo_oe
interface spi_regfile_rw_if;
  logic sclk;
  logic sdi;
  logic cs;
  logic sdo;
  logic sdo_oe;

  modport master (output sclk, output sdi, output cs, input sdo, input sdo_oe);
  modport slave  (input sclk, input sdi, input cs, output sdo, output sdo_oe);
endinterface

// File: rtl/spi_regfile_rw_sync_edge.sv
// sync_edge: STAGES-deep synchroniser for an asynchronous input, plus
// one-clk rise/fall pulses derived from the synchronised level.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised level (resets to RESET_VAL)
//   rise, fall : one-clk pulses on synchronised level changes
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_regfile_rw.sv
// spi_regfile_rw: SPI (mode 0) slave giving read/write access to NUM_REGS
// registers of DATA_W bits. Frame, MSB first: R/W bit, ADDR_W address bits,
// DATA_W data bits. Writes commit when cs rises after exactly FRAME_W bits.
//   clk, rst_n : system clock, async active-low reset
//   spi        : SPI pins (slave modport)
//   regs       : flattened register contents, register i at [i*DATA_W +: DATA_W]
//   wr_strobe  : one-clk pulse on bit i when register i is written
//   frame_err  : one-clk pulse when a frame is rejected
//   state      : current frame state (observability)
module spi_regfile_rw
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_rw_if.slave            spi,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err,
  output state_t                     state
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int HDR_W   = 1 + ADDR_W;
  // Shift register only needs to hold the header minus the bit being
  // received, or the data field, whichever is longer.
  localparam int SH_W    = (HDR_W - 1 > DATA_W) ? HDR_W - 1 : DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  logic       sclk_level_unused, sclk_rise, sclk_fall;
  logic       cs_s, cs_rise, cs_fall;
  logic       sdi_s;
  logic [1:0] sdi_edges_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi.sclk),
    .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi.cs),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(spi.sdi),
    .q(sdi_s), .rise(sdi_edges_unused[0]), .fall(sdi_edges_unused[1])
  );

  // The cs synchroniser resets to 1, so a cs pin already low at reset release
  // shows up as a falling edge. Frames are only accepted once cs has been
  // seen genuinely high after the synchroniser refilled with real samples.
  logic [SYNC_STAGES-1:0] settle;
  logic                   armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
      if (settle[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  logic [CNT_W-1:0]  cnt;
  logic [SH_W-1:0]   shreg;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_sh;
  logic              sdo_oe_q;
  logic [HDR_W-1:0]  hdr;
  logic [DATA_W-1:0] rd_val;
  logic              bit_take, frame_done, full, addr_ok, do_commit, do_err;
  state_t            state_n;

  // A cs rise synchronised together with an sclk edge finds cs_s already
  // high, so that bit is dropped.
  assign bit_take = sclk_rise & ~cs_s;
  assign hdr      = {shreg[HDR_W-2:0], sdi_s};

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cs_fall && armed) state_n = HDR;
      HDR: begin
        if (cs_rise) state_n = IDLE;
        else if (bit_take && cnt == CNT_W'(HDR_W - 1)) state_n = DATA;
      end
      DATA: begin
        if (cs_rise) state_n = IDLE;
        else if (bit_take && cnt == CNT_W'(FRAME_W)) state_n = OVF;
      end
      OVF: if (cs_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i*DATA_W +: DATA_W];
    end
  end

  assign frame_done = cs_rise && (state != IDLE);
  assign full       = (cnt == CNT_W'(FRAME_W));
  assign addr_ok    = {1'b0, addr_q} < (ADDR_W + 1)'(NUM_REGS);
  assign do_commit  = frame_done && full && (rw_q == RW_WRITE) && addr_ok;
  assign do_err     = frame_done && ((cnt != '0 && !full) ||
                                     (full && rw_q == RW_WRITE && !addr_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      rd_sh     <= '0;
      sdo_oe_q  <= 1'b0;
      regs      <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= do_err;

      if (state == IDLE) begin
        cnt <= '0;
      end else if (bit_take && state != OVF) begin
        shreg <= {shreg[SH_W-2:0], sdi_s};
        cnt   <= cnt + 1'b1;
      end

      if (state == HDR && state_n == DATA) begin
        rw_q   <= hdr[HDR_W-1];
        addr_q <= hdr[ADDR_W-1:0];
      end

      if (state == DATA && state_n != DATA) begin
        rd_sh    <= '0;
        sdo_oe_q <= 1'b0;
      end else if (state == HDR && state_n == DATA) begin
        if (hdr[HDR_W-1] == RW_READ) begin
          rd_sh    <= rd_val;
          sdo_oe_q <= 1'b1;
        end else begin
          rd_sh    <= '0;
          sdo_oe_q <= 1'b0;
        end
      end else if (state == DATA && sclk_fall && cnt > CNT_W'(HDR_W)) begin
        // The falling edge right after the last header bit must keep the
        // MSB on sdo for the first data rising edge; later falls advance.
        rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
      end

      if (do_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) begin
            regs[i*DATA_W +: DATA_W] <= shreg[DATA_W-1:0];
            wr_strobe[i]             <= 1'b1;
          end
        end
      end
    end
  end

  assign spi.sdo    = rd_sh[DATA_W-1];
  assign spi.sdo_oe = sdo_oe_q;

endmodule

// File: doc/spi_regfile_rw.md
SPI_REGFILE_RW -- requirements
Module: spi_regfile_rw

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of registers, 1..128.
REQ-002 SHALL have parameter DATA_W, default 8: register width in bits.
REQ-003 SHALL have parameter ADDR_W, default 7: address field width; NUM_REGS <= 2**ADDR_W.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, >= 2.
REQ-005 SHALL have port clk, input, 1: the single system clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port sclk, input, 1: SPI clock, asynchronous to clk, idle low (mode 0).
REQ-008 SHALL have port sdi, input, 1: SPI serial data in, MSB first.
REQ-009 SHALL have port cs, input, 1: SPI chip select, active low.
REQ-010 SHALL have port sdo, output, 1: SPI serial data out, read-back.
REQ-011 SHALL have port sdo_oe, output, 1: 1 while sdo is driven (read data phase only).
REQ-012 SHALL have port regs, output, NUM_REGS*DATA_W: flattened register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port wr_strobe, output, NUM_REGS: one-clk pulse on bit i when register i is committed.
REQ-014 SHALL have port frame_err, output, 1: one-clk pulse when a frame is rejected.

Function
REQ-015 SHALL pass sclk, sdi and cs through SYNC_STAGES flops on clk before any use; sclk frequency is limited to clk/8.
REQ-016 Frame SHALL be, MSB first: 1 R/W bit (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits; FRAME_W = 1+ADDR_W+DATA_W (16 at defaults).
REQ-017 SHALL sample sdi on each synchronised sclk rising edge while synchronised cs is low.
REQ-018 State machine SHALL have states IDLE, HDR, DATA, OVF.
REQ-019 IDLE->HDR on synchronised cs falling edge; bit counter cleared.
REQ-020 HDR->DATA after 1+ADDR_W bits are received; address and R/W latched.
REQ-021 DATA->OVF on a received bit beyond FRAME_W; OVF ignores further bits.
REQ-022 Any state->IDLE on synchronised cs rising edge; a cs rise in IDLE is ignored.
REQ-023 Write SHALL commit only when exactly FRAME_W bits were received, R/W=1 and address < NUM_REGS.
REQ-024 Commit SHALL update the register and pulse wr_strobe[addr] on the clk after the synchronised cs rise is detected; at most SYNC_STAGES+2 clk after the cs pin rises.
REQ-025 On entering DATA with R/W=0, SHALL load the read shifter with regs[addr], or all zeros if address >= NUM_REGS, and set sdo_oe=1.
REQ-026 sdo SHALL present the read MSB on entry to DATA and advance one bit on each synchronised sclk falling edge.
REQ-027 sdo_oe SHALL return to 0, and sdo to 0, on leaving DATA.
REQ-028 frame_err SHALL pulse at cs rise for a bit count that is nonzero and != FRAME_W, or for a write to address >= NUM_REGS; short and long frames never write.
REQ-029 A read to address >= NUM_REGS SHALL return zeros with no frame_err.
REQ-030 A frame with zero bits SHALL be silently ignored.
REQ-031 A cs rise and a sclk edge in the same synchronised cycle: the cs rise SHALL win and the bit is discarded.

Reset
REQ-032 While rst_n=0: all registers 0, regs=0, wr_strobe=0, frame_err=0, sdo=0, sdo_oe=0, state IDLE, synchronisers cleared to cs=1, sclk=0.
REQ-033 Reset mid-frame SHALL abort the frame with no commit.
REQ-034 If cs is low when reset releases, the frame SHALL be ignored until a fresh cs falling edge.

Structure
REQ-035 Shared package spi_regfile_pkg SHALL hold the state enum, the R/W encoding constants and the FRAME_W derivation function.
REQ-036 One sub-module, sync_edge, SHALL provide the SYNC_STAGES synchroniser with rise/fall pulse outputs; it is instantiated for sclk, cs and sdi (sdi edges unused).

Verification
REQ-037 Write 0x80 (addr 0, data 0xA5): regs[7:0]=0xA5; wr_strobe=0x01 for one clk; frame_err stays 0.
REQ-038 Write addr 3 = 0x3C, then read 0x03: sdo shifts 0x3C MSB first; sdo_oe=1 only during the 8 data bits.
REQ-039 15-bit write frame, then 17-bit write frame to addr 1: regs unchanged; frame_err pulses once per frame.
REQ-040 Write addr 0x10 with NUM_REGS=8: frame_err pulse, no strobe. Read addr 0x10: sdo=0x00, no frame_err.
REQ-041 Assert rst_n low after 9 bits of a write: regs=0 and state IDLE. cs is still low at release: no commit until a new cs falling edge.
REQ-042 Rerun REQ-037 and REQ-038 with NUM_REGS=32, DATA_W=16, ADDR_W=7 (24-bit frame): register 31 written 0xBEEF and read back 0xBEEF.
